// File: rtl/coin_acceptor.sv
// ---------------------------------------------------------------------------
// coin_acceptor
//   Front end of the vending machine. Cleans up the two raw, bouncy slot
//   sensors and turns them into single-cycle coin codes for the vending FSM.
//   Each sensor is synchronised, then debounced for both press and release.
//   A jam (both slots active) is rejected, and so is a coin inserted while
//   en is low. Accepted value is accumulated in half-yuan units and the
//   total saturates at all-ones.
//
// Parameters
//   DB_CYC     consecutive stable cycles required for press and for release
//              debounce (>= 1)
//   CNT_W      width of coin_cnt
//
// Ports
//   clk        system clock, rising edge
//   rstn       synchronous active-low reset
//   en         1 = accept coins, 0 = reject qualified coins
//   slot_half  raw 0.5-yuan sensor (asynchronous, may bounce)
//   slot_one   raw 1-yuan sensor (asynchronous, may bounce)
//   coin       registered one-cycle code: 00 none, 01 = 0.5, 10 = 1.0
//   reject     registered one-cycle pulse: jam, or coin while en = 0
//   coin_cnt   saturating total of accepted value, half-yuan units
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | both slots released and debounced, waiting for a coin
//   DEB      | one slot active, counting stable press cycles in dcnt
//   EMIT     | coin (en = 1) or reject (en = 0) pulse is being driven
//   JAM      | reject pulse for a jam is being driven
//   WAIT_REL | waiting for both slots to read 0
//   REL_DEB  | both slots 0, counting stable release cycles in dcnt
// ---------------------------------------------------------------------------
module coin_acceptor #(
    parameter int DB_CYC = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             slot_half,
    input  logic             slot_one,
    output logic [1:0]       coin,
    output logic             reject,
    output logic [CNT_W-1:0] coin_cnt
);

    localparam int DW = (DB_CYC < 2) ? 1 : $clog2(DB_CYC + 1);
    localparam logic [DW-1:0] DB_LIM = DW'(DB_CYC);
    localparam logic [DW-1:0] DCNT_ONE = DW'(1);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_HALF = 2'b01;
    localparam logic [1:0] CODE_ONE  = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEB      = 3'd1,
        EMIT     = 3'd2,
        JAM      = 3'd3,
        WAIT_REL = 3'd4,
        REL_DEB  = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    // Two-flop synchronisers; bit 1 is the synchronised value
    logic [1:0] sync_half;
    logic [1:0] sync_one;
    logic       s_half;
    logic       s_one;

    logic [DW-1:0]    dcnt;
    logic [DW-1:0]    dcnt_nxt;
    logic             kind;        // 0 = half-yuan slot latched, 1 = one-yuan slot
    logic             kind_nxt;
    logic [1:0]       coin_nxt;
    logic             reject_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W:0]   cnt_sum;
    logic             lat_in;
    logic             oth_in;

    assign s_half = sync_half[1];
    assign s_one  = sync_one[1];

    // Latched slot and the opposite slot, relative to the coin being debounced
    assign lat_in = kind ? s_one  : s_half;
    assign oth_in = kind ? s_half : s_one;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_half <= 2'b00;
            sync_one  <= 2'b00;
        end else begin
            sync_half <= {sync_half[0], slot_half};
            sync_one  <= {sync_one[0],  slot_one};
        end
    end

    // Reset parks the FSM in WAIT_REL so a coin held across reset must be
    // released and re-inserted before it can count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= WAIT_REL;
            dcnt     <= '0;
            kind     <= 1'b0;
            coin     <= CODE_NONE;
            reject   <= 1'b0;
            coin_cnt <= '0;
        end else begin
            state    <= state_nxt;
            dcnt     <= dcnt_nxt;
            kind     <= kind_nxt;
            coin     <= coin_nxt;
            reject   <= reject_nxt;
            coin_cnt <= cnt_nxt;
        end
    end

    // Outputs are computed on the transition into EMIT/JAM so the pulse is
    // registered on the state-entry edge; en is sampled on that same edge.
    always_comb begin
        state_nxt  = state;
        dcnt_nxt   = dcnt;
        kind_nxt   = kind;
        coin_nxt   = CODE_NONE;
        reject_nxt = 1'b0;
        cnt_nxt    = coin_cnt;
        cnt_sum    = {1'b0, coin_cnt} + (kind ? (CNT_W+1)'(2) : (CNT_W+1)'(1));

        case (state)
            IDLE: begin
                if (s_half && s_one) begin
                    state_nxt  = JAM;
                    reject_nxt = 1'b1;
                end else if (s_half || s_one) begin
                    kind_nxt  = s_one;
                    dcnt_nxt  = DCNT_ONE;
                    state_nxt = DEB;
                end
            end

            DEB: begin
                // A rising opposite slot wins over a dropping latched slot
                if (oth_in) begin
                    state_nxt  = JAM;
                    reject_nxt = 1'b1;
                end else if (!lat_in) begin
                    state_nxt = IDLE;
                end else if (dcnt == DB_LIM) begin
                    state_nxt = EMIT;
                    if (en) begin
                        coin_nxt = kind ? CODE_ONE : CODE_HALF;
                        cnt_nxt  = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end else begin
                    dcnt_nxt = dcnt + DCNT_ONE;
                end
            end

            EMIT: begin
                state_nxt = WAIT_REL;
            end

            JAM: begin
                state_nxt = WAIT_REL;
            end

            WAIT_REL: begin
                if (!s_half && !s_one) begin
                    dcnt_nxt  = DCNT_ONE;
                    state_nxt = REL_DEB;
                end
            end

            REL_DEB: begin
                if (s_half || s_one) begin
                    state_nxt = WAIT_REL;
                end else if (dcnt == DB_LIM) begin
                    state_nxt = IDLE;
                end else begin
                    dcnt_nxt = dcnt + DCNT_ONE;
                end
            end

            default: begin
                state_nxt = WAIT_REL;
            end
        endcase
    end

endmodule
